// File: rtl/matrix_inverse_pkg.sv
// Shared types and fixed-point helpers for the Gauss-Jordan matrix inverter.
package matrix_inverse_pkg;

  typedef enum logic [2:0] {
    LOAD,
    PIVOT,
    SWAP,
    RECIP,
    NORM,
    ELIM,
    OUT
  } state_t;

  // Fixed-point 1.0 for a given number of fractional bits (wide, callers cast down).
  function automatic logic signed [127:0] one_fx(input int frac);
    return 128'sd1 <<< frac;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fixed_recip_div.sv
// Sequential restoring unsigned divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per cycle, done pulses 2W+1 cycles after start.
module fixed_recip_div #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             done,
  output logic [2*W-1:0]   quotient
);

  localparam int CNTW = $clog2(2 * W + 1);

  logic [W-1:0]    rem;
  logic [W-1:0]    dv;
  logic [CNTW-1:0] cnt;
  logic            running;
  logic [W:0]      rem_sh;
  logic            fits;

  // Trial subtraction for the next quotient bit.
  always_comb begin
    rem_sh = {rem, quotient[2*W-1]};
    fits   = (rem_sh >= {1'b0, dv});
  end

  // Iteration counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running <= 1'b1;
        cnt     <= CNTW'(2 * W);
      end else if (running) begin
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // Remainder/quotient shift register; the quotient shifts in over the dividend.
  always_ff @(posedge clk) begin
    if (start) begin
      rem      <= '0;
      dv       <= divisor;
      quotient <= dividend;
    end else if (running) begin
      rem      <= fits ? W'(rem_sh - {1'b0, dv}) : rem_sh[W-1:0];
      quotient <= {quotient[2*W-2:0], fits};
    end
  end

endmodule

// File: rtl/matrix_inverse_gj.sv
// Streaming fixed-point matrix inverter using Gauss-Jordan elimination with
// partial pivoting over an N x 2N augmented array and one shared multiplier.
module matrix_inverse_gj
  import matrix_inverse_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                singular,
  output logic                busy
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  localparam logic [RW-1:0] LAST_R = RW'(N - 1);
  localparam logic [CW-1:0] LAST_C = CW'(2 * N - 1);
  localparam logic [CW-1:0] NCOL   = CW'(N);
  localparam logic [RW:0]   N_EXT  = (RW + 1)'(N);
  localparam logic signed [W-1:0] ONE = W'(one_fx(FRAC));
  localparam logic [2*W-1:0] DIVIDEND = {{(2*W-1){1'b0}}, 1'b1} << (2 * FRAC);

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    logic [W-1:0] r;
    r = v[W-1] ? -v : v;
    return r;
  endfunction

  state_t state, state_nx;

  logic signed [W-1:0] a [N][2*N];
  logic signed [W-1:0] f;
  logic signed [W-1:0] recip;
  logic [W-1:0]        bmag;
  logic [RW-1:0]       p;

  logic [RW-1:0] k, pr, i, ld_r, ld_c, o_r, o_c;
  logic [CW-1:0] j;
  logic          elim_lat;
  logic          div_run;

  logic                in_fire, out_fire;
  logic [W-1:0]        cur_mag, best_nx;
  logic                take;
  logic [RW-1:0]       p_nx, i_first;
  logic [RW:0]         i_a, i_b;
  logic                elim_row_last;
  logic signed [W-1:0] mul_a, mul_b;
  logic signed [2*W-1:0] prod, shifted;
  logic signed [127:0] shifted_x, elem_x, q_x;
  logic signed [W-1:0] nrm_val, elm_val, rcp_val;
  logic                piv_neg;
  logic [W-1:0]        divisor;
  logic [CW-1:0]       ld_col, oc_col;
  logic                div_start, div_done;
  logic [2*W-1:0]      quotient;

  fixed_recip_div #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  // Datapath combinational: pivot compare, row stepping, shared multiply, saturation.
  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    cur_mag  = mag(a[pr][k]);
    take     = (pr == k) || (cur_mag > bmag);
    best_nx  = take ? cur_mag : bmag;
    p_nx     = take ? pr : p;
    i_a      = {1'b0, i} + (RW + 1)'(1);
    i_b      = (i_a == {1'b0, k}) ? i_a + (RW + 1)'(1) : i_a;
    elim_row_last = (i_b >= N_EXT);
    i_first  = (k == '0) ? RW'(1) : '0;
    mul_a    = (state == NORM) ? recip : f;
    mul_b    = a[k][j];
    prod     = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
    shifted  = prod >>> FRAC;
    shifted_x = $signed({{(128-2*W){shifted[2*W-1]}}, shifted});
    elem_x   = $signed({{(128-W){a[i][j][W-1]}}, a[i][j]});
    nrm_val  = W'(saturate(shifted_x, W));
    elm_val  = W'(saturate(elem_x - shifted_x, W));
    piv_neg  = a[k][k][W-1];
    divisor  = mag(a[k][k]);
    q_x      = $signed({{(128-2*W){1'b0}}, quotient});
    rcp_val  = W'(saturate(piv_neg ? -q_x : q_x, W));
    ld_col   = CW'(ld_c);
    oc_col   = NCOL + CW'(o_c);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    in_ready  = (state == LOAD);
    busy      = (state != LOAD);
    out_valid = (state == OUT);
    out_data  = (state == OUT && !singular) ? a[o_r][oc_col] : '0;
    case (state)
      LOAD:  if (in_fire && ld_r == LAST_R && ld_c == LAST_R) state_nx = PIVOT;
      PIVOT: if (pr == LAST_R) state_nx = (best_nx == '0) ? OUT : SWAP;
      SWAP:  state_nx = RECIP;
      RECIP: begin
        div_start = !div_run;
        if (div_done) state_nx = NORM;
      end
      NORM:  if (j == LAST_C) state_nx = ELIM;
      ELIM:  if (!elim_lat && j == LAST_C && elim_row_last) state_nx = (k == LAST_R) ? OUT : PIVOT;
      OUT:   if (out_fire && o_r == LAST_R && o_c == LAST_R) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Control registers: state, column/row counters, singular flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      k        <= '0;
      pr       <= '0;
      i        <= '0;
      j        <= '0;
      ld_r     <= '0;
      ld_c     <= '0;
      o_r      <= '0;
      o_c      <= '0;
      elim_lat <= 1'b0;
      singular <= 1'b0;
      div_run  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (in_fire) begin
          if (ld_c == LAST_R) begin
            ld_c <= '0;
            if (ld_r == LAST_R) begin
              ld_r <= '0;
              k    <= '0;
              pr   <= '0;
            end else begin
              ld_r <= ld_r + RW'(1);
            end
          end else begin
            ld_c <= ld_c + RW'(1);
          end
        end
        PIVOT: begin
          if (pr != LAST_R) pr <= pr + RW'(1);
          else if (best_nx == '0) singular <= 1'b1;
        end
        RECIP: begin
          j <= '0;
          if (div_start) div_run <= 1'b1;
          if (div_done) div_run <= 1'b0;
        end
        NORM: begin
          if (j == LAST_C) begin
            j        <= '0;
            i        <= i_first;
            elim_lat <= 1'b1;
          end else begin
            j <= j + CW'(1);
          end
        end
        ELIM: begin
          if (elim_lat) begin
            elim_lat <= 1'b0;
            j        <= '0;
          end else if (j == LAST_C) begin
            j <= '0;
            if (elim_row_last) begin
              if (k != LAST_R) begin
                k  <= k + RW'(1);
                pr <= k + RW'(1);
              end
            end else begin
              i        <= i_b[RW-1:0];
              elim_lat <= 1'b1;
            end
          end else begin
            j <= j + CW'(1);
          end
        end
        OUT: if (out_fire) begin
          if (o_c == LAST_R) begin
            o_c <= '0;
            if (o_r == LAST_R) begin
              o_r      <= '0;
              k        <= '0;
              singular <= 1'b0;
            end else begin
              o_r <= o_r + RW'(1);
            end
          end else begin
            o_c <= o_c + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Augmented array and arithmetic registers; every word is rewritten by LOAD before use.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: if (in_fire) begin
        a[ld_r][ld_col]        <= in_data;
        a[ld_r][NCOL + ld_col] <= (ld_r == ld_c) ? ONE : '0;
      end
      PIVOT: begin
        bmag <= best_nx;
        p    <= p_nx;
      end
      SWAP: begin
        for (int c = 0; c < 2 * N; c++) begin
          a[k][c[CW-1:0]] <= a[p][c[CW-1:0]];
          a[p][c[CW-1:0]] <= a[k][c[CW-1:0]];
        end
      end
      RECIP: if (div_done) recip <= rcp_val;
      NORM:  a[k][j] <= nrm_val;
      ELIM: begin
        if (elim_lat) f <= a[i][k];
        else          a[i][j] <= elm_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_inverse_gj.sv
// Scoreboard bench: a real-valued Gauss-Jordan model predicts each inverse,
// an independent monitor pops and compares every output word.
module tb_matrix_inverse_gj;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [W-1:0] in_data = '0;
  logic in_ready, out_valid, singular, busy;
  logic signed [W-1:0] out_data;

  always #5 clk = ~clk;

  matrix_inverse_gj #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .singular  (singular),
    .busy      (busy)
  );

  typedef struct {
    int data;
    int tol;
    bit sing;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rand_ready = 1'b0;
  int   mat [N][N];

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, expv);
  endtask

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Reference: real-valued Gauss-Jordan inverse with partial pivoting.
  task automatic push_expected(input int tol);
    real m [N][2*N];
    real piv, fct, t;
    int  best_r;
    bit  sing;
    exp_t e;
    sing = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < 2 * N; c++)
        m[r][c] = (c < N) ? real'(mat[r][c]) / 65536.0 : ((c - N == r) ? 1.0 : 0.0);
    for (int col = 0; col < N; col++) begin
      best_r = col;
      for (int r = col + 1; r < N; r++)
        if (rabs(m[r][col]) > rabs(m[best_r][col])) best_r = r;
      if (m[best_r][col] == 0.0) begin
        sing = 1'b1;
        break;
      end
      for (int c = 0; c < 2 * N; c++) begin
        t = m[col][c]; m[col][c] = m[best_r][c]; m[best_r][c] = t;
      end
      piv = m[col][col];
      for (int c = 0; c < 2 * N; c++) m[col][c] = m[col][c] / piv;
      for (int r = 0; r < N; r++) begin
        if (r != col) begin
          fct = m[r][col];
          for (int c = 0; c < 2 * N; c++) m[r][c] = m[r][c] - fct * m[col][c];
        end
      end
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.data = sing ? 0 : rnd(m[r][N + c] * 65536.0);
        e.tol  = sing ? 0 : tol;
        e.sing = sing;
        sb.push_back(e);
      end
  endtask

  task automatic set_diag(input int d0, input int d1, input int d2, input int d3);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = 0;
    mat[0][0] = d0; mat[1][1] = d1; mat[2][2] = d2; mat[3][3] = d3;
  endtask

  task automatic make_random();
    int tmp [N][N];
    int rot;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (r == c) begin
          tmp[r][c] = int'($urandom_range(4, 7) << 16) + int'($urandom_range(0, 65535));
          if ($urandom_range(0, 1) == 1) tmp[r][c] = -tmp[r][c];
        end else begin
          tmp[r][c] = int'($urandom_range(0, 131072)) - 65536;
        end
      end
    rot = int'($urandom_range(0, N - 1));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = tmp[(r + rot) % N][c];
  endtask

  // Called at posedge+1; leaves in_valid high with junk when junk_after is set.
  task automatic send_matrix(input bit junk_after);
    int guard;
    for (int idx = 0; idx < N * N; idx++) begin
      in_valid = 1'b1;
      in_data  = mat[idx / N][idx % N];
      guard = 0;
      while (!in_ready && guard < 2000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 2000) begin
        n_checks++;
        $display("FAIL load_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
    end
    in_valid = junk_after;
    in_data  = 32'h5A5A_1234;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20000) begin
      @(posedge clk); #1;
      if (out_valid) in_valid = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 20000) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  bit stall_prev = 1'b0;
  logic signed [W-1:0] data_prev = '0;
  exp_t mon_e;
  longint mon_d;

  // Monitor: drives out_ready, checks held data during stalls, pops and compares each transfer.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      out_ready  = 1'b1;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (out_valid && out_data == data_prev) n_pass++;
        else $display("FAIL hold: valid %0b data %h, required valid 1 data %h", out_valid, out_data, data_prev);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL extra_word: got %h, required no word", out_data);
        end else begin
          mon_e = sb.pop_front();
          mon_d = longint'(out_data) - longint'(mon_e.data);
          if (mon_d < 0) mon_d = -mon_d;
          if (mon_d <= longint'(mon_e.tol) && singular == mon_e.sing) n_pass++;
          else $display("FAIL word: got %h sing %0b, required %h (tol %0d) sing %0b",
                        out_data, singular, mon_e.data, mon_e.tol, mon_e.sing);
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_singular", singular, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // identity
    set_diag(32'h10000, 32'h10000, 32'h10000, 32'h10000);
    push_expected(0);
    send_matrix(1'b0);
    drain();

    // diag(2,4,-8,0.5) with junk held on in_valid while busy
    set_diag(32'h20000, 32'h40000, -32'sh80000, 32'h8000);
    push_expected(0);
    send_matrix(1'b1);
    drain();

    // identity with rows 0 and 1 exchanged
    set_diag(0, 0, 32'h10000, 32'h10000);
    mat[0][1] = 32'h10000;
    mat[1][0] = 32'h10000;
    push_expected(0);
    send_matrix(1'b0);
    drain();

    // row 2 duplicates row 0
    mat = '{'{32'h10000, 32'h20000, 32'h30000, 32'h40000},
            '{0,         32'h10000, 32'h50000, 32'h20000},
            '{32'h10000, 32'h20000, 32'h30000, 32'h40000},
            '{0,         0,         32'h10000, 32'h70000}};
    push_expected(0);
    rand_ready = 1'b1;
    send_matrix(1'b0);
    drain();
    check("sing_cleared", singular, 0);
    check("sing_in_ready", in_ready, 1);

    // dense well-conditioned matrices with random back-pressure
    for (int t = 0; t < 6; t++) begin
      make_random();
      push_expected(64);
      send_matrix(1'b0);
      drain();
    end
    rand_ready = 1'b0;

    // reset in the middle of the reciprocal, then a fresh identity
    make_random();
    send_matrix(1'b0);
    repeat (10) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("in_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_singular", singular, 0);
    check("post_rst_out_data", out_data, 0);
    set_diag(32'h10000, 32'h10000, 32'h10000, 32'h10000);
    push_expected(0);
    send_matrix(1'b0);
    drain();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
